// File: rtl/itype_pkg.sv
// Shared definitions for the I-type sequencer: opcodes, FSM states,
// writeback select encoding and the supported-opcode decoder.
package itype_pkg;

  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  // Register-file write data source.
  typedef enum logic {
    WSEL_ALU = 1'b0,
    WSEL_MEM = 1'b1
  } wsel_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LUI, OP_SLTI, OP_SLTIU,
      OP_BEQ, OP_BNE, OP_LW, OP_SW: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/itype_controller_if.sv
// Bus bundle between the I-type sequencer and imem / register file / ALU / dmem.
//
// Handshake (imem and dmem alike): the controller raises req and holds it,
// with address and write enable stable, until it samples ack=1 on a rising
// edge; req drops in the following cycle. ack is only looked at while req=1,
// so an ack arriving with req=0 has no effect.
interface itype_controller_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_imm;
  logic        alu_zero;
  logic        alu_ovf;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        rf_wsel;

  modport master (
    output imem_req, imem_addr, rs_addr, rt_addr, alu_opcode, alu_imm,
           dmem_req, dmem_we, rf_we, rf_waddr, rf_wsel,
    input  imem_ack, imem_rdata, alu_zero, alu_ovf, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, rs_addr, rt_addr, alu_opcode, alu_imm,
           dmem_req, dmem_we, rf_we, rf_waddr, rf_wsel,
    output imem_ack, imem_rdata, alu_zero, alu_ovf, dmem_ack
  );
endinterface

// File: rtl/itype_imm_ext.sv
// Immediate extender: turns the 16-bit instruction immediate into the 32-bit
// ALU operand. Branches are sign-extended, so the same output also serves as
// the branch word offset.
module itype_imm_ext
  import itype_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [15:0] imm16,
  output logic [31:0] imm32
);

  // Zero-extend logical ops, shift LUI into the upper half, sign-extend the rest
  always_comb begin
    imm32 = {{16{imm16[15]}}, imm16};
    case (opcode)
      OP_ANDI, OP_ORI: imm32 = {16'h0000, imm16};
      OP_LUI:          imm32 = {imm16, 16'h0000};
      default:         imm32 = {{16{imm16[15]}}, imm16};
    endcase
  end

endmodule

// File: rtl/itype_controller.sv
// Multi-cycle I-type sequencer: fetch, decode, execute, then complete by
// writeback, data-memory handshake or branch resolution. Owns the PC.
// Optional feature macro: ITYPE_CTRL_OVF_TRAP_EN (ADDI overflow halts with
// fault instead of writing back the wrapped result).
module itype_controller
  import itype_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  itype_controller_if.master bus,
  output logic [31:0]        pc,
  output logic               busy,
  output logic               illegal,
  output logic               fault,
  output state_t             dbg_state
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t        state, state_next, done_state;
  logic [31:0]   ir, pc_next, imm32, pc_plus4, br_target;
  logic [CW-1:0] cnt;
  logic [5:0]    opcode;
  logic          is_lw, is_sw, is_mem, is_branch, taken;
  logic          mem_phase, waiting, ack, timeout;
  logic          ir_load, set_illegal, set_fault;

  assign opcode    = ir[31:26];
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_mem    = is_lw | is_sw;
  assign is_branch = (opcode == OP_BEQ) | (opcode == OP_BNE);
  assign taken     = (opcode == OP_BEQ) ? bus.alu_zero : ~bus.alu_zero;

  // The data request is raised already in EXECUTE so a zero-wait memory
  // completes in a single MEM cycle; the request then stays up through MEM.
  assign mem_phase = (state == S_MEM) | ((state == S_EXECUTE) & is_mem);
  assign waiting   = (state == S_FETCH) | mem_phase;
  assign ack       = (state == S_FETCH) ? bus.imem_ack : (mem_phase & bus.dmem_ack);
  // ack has priority: a timeout only counts when no ack is present.
  assign timeout   = waiting & ~ack & (cnt == CNT_LAST);

  assign done_state = run ? S_FETCH : S_IDLE;

  itype_imm_ext u_imm_ext (
    .opcode (opcode),
    .imm16  (ir[15:0]),
    .imm32  (imm32)
  );

  assign pc_plus4  = pc + 32'd4;
  assign br_target = pc_plus4 + {imm32[29:0], 2'b00};

  // Next-state, PC update and sticky-flag set requests
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_load     = 1'b0;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (ack) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          set_fault  = 1'b1;
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        if (op_supported(opcode)) begin
          state_next = S_EXECUTE;
        end else begin
          set_illegal = 1'b1;
          state_next  = S_HALT;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_next    = taken ? br_target : pc_plus4;
          state_next = done_state;
        end else if (is_mem) begin
          state_next = S_MEM;
          if (ack) begin
            if (is_sw) begin
              pc_next    = pc_plus4;
              state_next = done_state;
            end else begin
              state_next = S_WB;
            end
          end else if (timeout) begin
            set_fault  = 1'b1;
            state_next = S_HALT;
          end
`ifdef ITYPE_CTRL_OVF_TRAP_EN
        end else if ((opcode == OP_ADDI) && bus.alu_ovf) begin
          set_fault  = 1'b1;
          state_next = S_HALT;
`endif
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (ack) begin
          if (is_sw) begin
            pc_next    = pc_plus4;
            state_next = done_state;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout) begin
          set_fault  = 1'b1;
          state_next = S_HALT;
        end
      end
      S_WB: begin
        pc_next    = pc_plus4;
        state_next = done_state;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, PC and sticky status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      illegal <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (set_illegal) illegal <= 1'b1;
      if (set_fault)   fault   <= 1'b1;
    end
  end

  // Instruction register, loaded when the fetch is acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ir <= 32'h0;
    else if (ir_load) ir <= bus.imem_rdata;
  end

  // Ack wait counter, restarted for every new request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (waiting && !ack && !timeout) cnt <= cnt + 1'b1;
    else                                 cnt <= '0;
  end

`ifndef ITYPE_CTRL_OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = bus.alu_ovf;
`endif

  assign bus.imem_req   = (state == S_FETCH);
  assign bus.imem_addr  = pc;
  assign bus.rs_addr    = ir[25:21];
  assign bus.rt_addr    = ir[20:16];
  assign bus.alu_opcode = opcode;
  assign bus.alu_imm    = imm32;
  assign bus.dmem_req   = mem_phase;
  assign bus.dmem_we    = mem_phase & is_sw;
  assign bus.rf_we      = (state == S_WB);
  assign bus.rf_waddr   = ir[20:16];
  assign bus.rf_wsel    = ((state == S_WB) && is_lw) ? WSEL_MEM : WSEL_ALU;
  assign busy           = (state != S_IDLE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_itype_controller.sv
// Bench for itype_controller: table of single-instruction runs plus
// hand-written sequences for overflow, illegal opcode, ack timeout and
// reset during a pending fetch. Register writes go through an expected queue.
module tb_itype_controller;
  import itype_pkg::*;

  localparam int          ACK_TIMEOUT = 16;
  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          W           = 10;   // {cycle[3:0], waddr[4:0], wsel}
  localparam int          NV          = 18;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        zero;
    logic        ovf;
    int          dack;
    logic [31:0] exp_imm;
    logic [31:0] exp_pc;
    logic        exp_we;
    logic        exp_wsel;
    int          exp_busy;
    int          exp_dreq;
    int          exp_dwe;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] pc;
  logic        busy, illegal, fault;
  state_t      dbg_state;

  itype_controller_if bus ();

  itype_controller #(
    .RESET_PC    (RESET_PC),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .bus       (bus),
    .pc        (pc),
    .busy      (busy),
    .illegal   (illegal),
    .fault     (fault),
    .dbg_state (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp, mon_got;
  int          op_cyc;
  int          imem_ack_at = 2;   // ack in the n-th cycle of an active request; 0 = never
  int          dmem_ack_at = 2;
  int          icnt, dcnt;
  logic [31:0] cur_pc;
  vec_t        vecs[NV];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- memory responders ----------------
  initial begin
    icnt = 0;
    bus.imem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.imem_req) begin
        icnt++;
        bus.imem_ack = (icnt == imem_ack_at);
      end else begin
        icnt = 0;
        bus.imem_ack = 1'b0;
      end
    end
  end

  initial begin
    dcnt = 0;
    bus.dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        dcnt++;
        bus.dmem_ack = (dcnt == dmem_ack_at);
      end else begin
        dcnt = 0;
        bus.dmem_ack = 1'b0;
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- writeback scoreboard ----------------
  initial begin
    op_cyc = 0;
    forever begin
      @(negedge clk);
      if (busy) op_cyc++;
      else      op_cyc = 0;
      if (bus.rf_we === 1'b1) begin
        mon_got = {4'(op_cyc), bus.rf_waddr, bus.rf_wsel};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rf_we unexpected: waddr %0d at cycle %0d, required no write",
                   bus.rf_waddr, op_cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rf_we {cycle,waddr,wsel}", 32'(mon_got), 32'(mon_exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string tag);
    run   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " state"},     dbg_state,      S_IDLE);
    check({tag, " pc"},        pc,             RESET_PC);
    check({tag, " busy"},      busy,           1'b0);
    check({tag, " illegal"},   illegal,        1'b0);
    check({tag, " fault"},     fault,          1'b0);
    check({tag, " imem_req"},  bus.imem_req,   1'b0);
    check({tag, " dmem_req"},  bus.dmem_req,   1'b0);
    check({tag, " dmem_we"},   bus.dmem_we,    1'b0);
    check({tag, " rf_we"},     bus.rf_we,      1'b0);
    check({tag, " rf_wsel"},   bus.rf_wsel,    1'b0);
    check({tag, " rf_waddr"},  bus.rf_waddr,   5'd0);
    check({tag, " rs/rt"},     {bus.rs_addr, bus.rt_addr}, 10'd0);
    check({tag, " alu_op"},    bus.alu_opcode, 6'd0);
    check({tag, " alu_imm"},   bus.alu_imm,    32'h0);
    rst_n  = 1'b1;
    cur_pc = RESET_PC;
    @(negedge clk);
  endtask

  task automatic run_one(input vec_t v, input string tag);
    int nb, nd, nw;
    bus.imem_rdata = {v.op, v.rs, v.rt, v.imm};
    bus.alu_zero   = v.zero;
    bus.alu_ovf    = v.ovf;
    imem_ack_at    = 2;
    dmem_ack_at    = v.dack;
    if (v.exp_we) exp_q.push_back({4'(v.exp_busy), v.rt, v.exp_wsel});
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    check({tag, " imem_addr"}, bus.imem_addr, cur_pc);
    nb = 0; nd = 0; nw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (bus.dmem_req) nd++;
      if (bus.dmem_we)  nw++;
      if (dbg_state == S_EXECUTE) begin
        check({tag, " alu_opcode"}, bus.alu_opcode, v.op);
        check({tag, " alu_imm"},    bus.alu_imm,    v.exp_imm);
        check({tag, " rs/rt"},      {bus.rs_addr, bus.rt_addr}, {v.rs, v.rt});
      end
    end
    check({tag, " busy cycles"}, nb, v.exp_busy);
    check({tag, " dmem_req cycles"}, nd, v.exp_dreq);
    check({tag, " dmem_we cycles"},  nw, v.exp_dwe);
    check({tag, " pc"}, pc, v.exp_pc);
    cur_pc = v.exp_pc;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n;
    vec_t v;
    rst_n          = 1'b0;
    run            = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.alu_zero   = 1'b0;
    bus.alu_ovf    = 1'b0;
    cur_pc         = RESET_PC;

    //        op        rs     rt     imm       z     ovf  dack exp_imm        exp_pc         we    wsel  busy dreq dwe
    vecs[0]  = '{OP_BEQ,   5'd1,  5'd2,  16'hFFFE, 1'b1, 1'b0, 2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0, 1'b0, 4, 0, 0};
    vecs[1]  = '{OP_ADDI,  5'd5,  5'd7,  16'hFFFF, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 5, 0, 0};
    vecs[2]  = '{OP_ANDI,  5'd1,  5'd2,  16'h8001, 1'b0, 1'b0, 2, 32'h0000_8001, 32'h0000_0004, 1'b1, 1'b0, 5, 0, 0};
    vecs[3]  = '{OP_ORI,   5'd3,  5'd3,  16'hFFFF, 1'b0, 1'b0, 2, 32'h0000_FFFF, 32'h0000_0008, 1'b1, 1'b0, 5, 0, 0};
    vecs[4]  = '{OP_LUI,   5'd0,  5'd4,  16'h1234, 1'b0, 1'b0, 2, 32'h1234_0000, 32'h0000_000C, 1'b1, 1'b0, 5, 0, 0};
    vecs[5]  = '{OP_SLTI,  5'd6,  5'd0,  16'h8000, 1'b0, 1'b0, 2, 32'hFFFF_8000, 32'h0000_0010, 1'b1, 1'b0, 5, 0, 0};
    vecs[6]  = '{OP_ADDIU, 5'd7,  5'd31, 16'h7FFF, 1'b0, 1'b0, 2, 32'h0000_7FFF, 32'h0000_0014, 1'b1, 1'b0, 5, 0, 0};
    vecs[7]  = '{OP_SLTIU, 5'd8,  5'd10, 16'h0001, 1'b0, 1'b0, 2, 32'h0000_0001, 32'h0000_0018, 1'b1, 1'b0, 5, 0, 0};
    vecs[8]  = '{OP_BEQ,   5'd2,  5'd3,  16'h0039, 1'b1, 1'b0, 2, 32'h0000_0039, 32'h0000_0100, 1'b0, 1'b0, 4, 0, 0};
    vecs[9]  = '{OP_BEQ,   5'd2,  5'd3,  16'h0003, 1'b0, 1'b0, 2, 32'h0000_0003, 32'h0000_0104, 1'b0, 1'b0, 4, 0, 0};
    vecs[10] = '{OP_BEQ,   5'd1,  5'd1,  16'hFFFE, 1'b1, 1'b0, 2, 32'hFFFF_FFFE, 32'h0000_0100, 1'b0, 1'b0, 4, 0, 0};
    vecs[11] = '{OP_BEQ,   5'd2,  5'd3,  16'h0003, 1'b1, 1'b0, 2, 32'h0000_0003, 32'h0000_0110, 1'b0, 1'b0, 4, 0, 0};
    vecs[12] = '{OP_BNE,   5'd2,  5'd3,  16'h0003, 1'b1, 1'b0, 2, 32'h0000_0003, 32'h0000_0114, 1'b0, 1'b0, 4, 0, 0};
    vecs[13] = '{OP_BNE,   5'd4,  5'd5,  16'hFFFF, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'h0000_0114, 1'b0, 1'b0, 4, 0, 0};
    vecs[14] = '{OP_LW,    5'd29, 5'd9,  16'hFFFC, 1'b0, 1'b0, 2, 32'hFFFF_FFFC, 32'h0000_0118, 1'b1, 1'b1, 6, 2, 0};
    vecs[15] = '{OP_LW,    5'd29, 5'd11, 16'h0008, 1'b0, 1'b0, 4, 32'h0000_0008, 32'h0000_011C, 1'b1, 1'b1, 8, 4, 0};
    vecs[16] = '{OP_SW,    5'd29, 5'd12, 16'h0010, 1'b0, 1'b0, 2, 32'h0000_0010, 32'h0000_0120, 1'b0, 1'b0, 5, 2, 2};
    vecs[17] = '{OP_SW,    5'd29, 5'd13, 16'h8004, 1'b0, 1'b0, 3, 32'hFFFF_8004, 32'h0000_0124, 1'b0, 1'b0, 6, 3, 3};

    do_reset("reset");

    for (int i = 0; i < NV; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // ADDI with ALU overflow
    do_reset("reset2");
`ifdef ITYPE_CTRL_OVF_TRAP_EN
    bus.imem_rdata = {OP_ADDI, 5'd1, 5'd6, 16'h0001};
    bus.alu_zero   = 1'b0;
    bus.alu_ovf    = 1'b1;
    imem_ack_at    = 2;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dbg_state == S_HALT) break;
    end
    repeat (3) @(negedge clk);
    check("ovf state", dbg_state, S_HALT);
    check("ovf fault", fault, 1'b1);
    check("ovf busy", busy, 1'b1);
    check("ovf pc", pc, RESET_PC);
    bus.alu_ovf = 1'b0;
`else
    v = '{OP_ADDI, 5'd1, 5'd6, 16'h0001, 1'b0, 1'b1, 2, 32'h0000_0001, 32'h0000_0004, 1'b1, 1'b0, 5, 0, 0};
    run_one(v, "ovf");
    check("ovf fault", fault, 1'b0);
    bus.alu_ovf = 1'b0;
`endif

    // Illegal opcode halts; run held high must not restart fetching
    do_reset("reset3");
    bus.imem_rdata = {6'b111111, 5'd1, 5'd2, 16'h0000};
    imem_ack_at    = 2;
    run = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    check("illegal flag", illegal, 1'b1);
    check("illegal state", dbg_state, S_HALT);
    check("illegal busy", busy, 1'b1);
    check("illegal imem_req cycles", n, 2);
    check("illegal fault", fault, 1'b0);
    run = 1'b0;

    // imem_ack never arrives
    do_reset("reset4");
    imem_ack_at = 0;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    n = 0;
    for (int i = 0; i < ACK_TIMEOUT + 10; i++) begin
      @(negedge clk);
      if (fault) break;
      if (bus.imem_req) n++;
    end
    check("timeout req cycles", n, ACK_TIMEOUT);
    check("timeout fault", fault, 1'b1);
    check("timeout state", dbg_state, S_HALT);
    check("timeout imem_req", bus.imem_req, 1'b0);
    check("timeout illegal", illegal, 1'b0);

    // Reset asserted while a fetch is pending
    do_reset("reset5");
    v = '{OP_ADDI, 5'd5, 5'd7, 16'hFFFF, 1'b0, 1'b0, 2, 32'hFFFF_FFFF, 32'h0000_0004, 1'b1, 1'b0, 5, 0, 0};
    run_one(v, "addi0");
    imem_ack_at = 0;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (5) @(negedge clk);
    check("midwait imem_req", bus.imem_req, 1'b1);
    check("midwait pc", pc, 32'h0000_0004);
    #2 rst_n = 1'b0;
    #1;
    check("async reset imem_req", bus.imem_req, 1'b0);
    check("async reset pc", pc, RESET_PC);
    check("async reset busy", busy, 1'b0);
    imem_ack_at = 2;
    do_reset("reset6");

    check("scoreboard drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
